// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control, debug-load and branch-target inputs plus the
// fetched instruction / PC outputs handed to the IF/ID register.
interface fetch_unit_if #(
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32
);
  logic               i_stall;
  logic               i_debug_unit;
  logic               i_mem_wen;
  logic               i_mem_ren;
  logic [NB_INST-1:0] i_mem_data;
  logic [NB_DATA-1:0] i_wr_addr;
  logic [1:0]         i_pc_src;
  logic [NB_DATA-1:0] i_addr_register;
  logic [NB_DATA-1:0] i_addr_branch;
  logic [NB_DATA-1:0] i_addr_jump;
  logic               i_jump_or_branch;
  logic [NB_INST-1:0] o_instruction;
  logic [NB_DATA-1:0] o_pc;
  logic [NB_DATA-1:0] o_next_pc;

  modport master (
    output i_stall, i_debug_unit, i_mem_wen, i_mem_ren, i_mem_data, i_wr_addr,
           i_pc_src, i_addr_register, i_addr_branch, i_addr_jump, i_jump_or_branch,
    input  o_instruction, o_pc, o_next_pc
  );

  modport slave (
    input  i_stall, i_debug_unit, i_mem_wen, i_mem_ren, i_mem_data, i_wr_addr,
           i_pc_src, i_addr_register, i_addr_branch, i_addr_jump, i_jump_or_branch,
    output o_instruction, o_pc, o_next_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, PC+4, next-PC select and word memory.
// Optional FETCH_BRANCH_NOP_EN squashes the delay slot with a NOP on taken jumps/branches.
module fetch_unit #(
  parameter int NB_INST   = 32,
  parameter int NB_DATA   = 32,
  parameter int MEM_SIZEB = 256
) (
  input  logic       i_clk,
  input  logic       i_reset,
  fetch_unit_if.slave io_bus
);
  localparam int MEM_DEPTH = MEM_SIZEB / 4;
  localparam int NB_IDX    = $clog2(MEM_DEPTH);

  logic [NB_INST-1:0] r_mem [MEM_DEPTH];
  logic [NB_DATA-1:0] r_pc;
  logic [NB_INST-1:0] r_instruction;

  logic [NB_DATA-1:0] w_next_pc;
  logic [NB_DATA-1:0] w_target;
  logic [NB_DATA-1:0] w_pc_d;
  logic [NB_DATA-1:0] w_mem_addr;
  logic [NB_DATA-1:0] w_addr_shifted;
  logic [NB_IDX-1:0]  w_word_idx;
  logic [NB_INST-1:0] w_fetch_word;
  logic               w_pc_en;
  logic               w_rd_en;

  assign w_next_pc = r_pc + NB_DATA'(4);

  always_comb begin
    w_target = io_bus.i_addr_register;
    case (io_bus.i_pc_src)
      2'b01:   w_target = io_bus.i_addr_branch;
      2'b10:   w_target = io_bus.i_addr_jump;
      default: w_target = io_bus.i_addr_register;
    endcase
  end

  assign w_pc_d = io_bus.i_jump_or_branch ? w_target : w_next_pc;

  // Byte offset and address bits above the array size are dropped, so addresses alias.
  assign w_mem_addr     = io_bus.i_debug_unit ? io_bus.i_wr_addr : r_pc;
  assign w_addr_shifted = w_mem_addr >> 2;
  assign w_word_idx     = NB_IDX'(w_addr_shifted);

`ifdef FETCH_BRANCH_NOP_EN
  localparam logic [NB_INST-1:0] NOP_INST = NB_INST'(32'hF800_0000);
  assign w_fetch_word = io_bus.i_jump_or_branch ? NOP_INST : r_mem[w_word_idx];
`else
  assign w_fetch_word = r_mem[w_word_idx];
`endif

  assign w_pc_en = !io_bus.i_stall && !io_bus.i_debug_unit;
  assign w_rd_en = !io_bus.i_stall && io_bus.i_mem_ren;

  // Debug loads bypass reset and stall so a program can be written at any time.
  always_ff @(posedge i_clk) begin
    if (io_bus.i_debug_unit && io_bus.i_mem_wen)
      r_mem[w_word_idx] <= io_bus.i_mem_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc          <= '0;
      r_instruction <= '0;
    end else begin
      if (w_pc_en) r_pc <= w_pc_d;
      if (w_rd_en) r_instruction <= w_fetch_word;
    end
  end

  assign io_bus.o_pc          = r_pc;
  assign io_bus.o_next_pc     = w_next_pc;
  assign io_bus.o_instruction = r_instruction;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, debug load, sequential fetch, targets,
// stall, PC wrap/aliasing, mid-run reset and read-before-write.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  fetch_unit_if #(.NB_INST(32), .NB_DATA(32)) bus ();

  fetch_unit #(.NB_INST(32), .NB_DATA(32), .MEM_SIZEB(256)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_BRANCH_NOP_EN
  localparam bit NOP_ON = 1'b1;
`else
  localparam bit NOP_ON = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dbg_write(input logic [31:0] addr, input logic [31:0] data);
    bus.i_debug_unit = 1'b1;
    bus.i_mem_wen    = 1'b1;
    bus.i_wr_addr    = addr;
    bus.i_mem_data   = data;
    tick();
  endtask

  logic [31:0] held;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.i_stall = 1'b0;        bus.i_debug_unit = 1'b0;
    bus.i_mem_wen = 1'b0;      bus.i_mem_ren = 1'b0;
    bus.i_mem_data = '0;       bus.i_wr_addr = '0;
    bus.i_pc_src = 2'b00;      bus.i_addr_register = '0;
    bus.i_addr_branch = '0;    bus.i_addr_jump = '0;
    bus.i_jump_or_branch = 1'b0;

    tick();
    rst = 1'b0;
    check("reset_pc", bus.o_pc, 32'h0);
    check("reset_instr", bus.o_instruction, 32'h0);
    check("reset_next_pc", bus.o_next_pc, 32'h4);

    // Program load through the debug port
    dbg_write(32'h00, 32'h1111_1111);
    dbg_write(32'h04, 32'h2222_2222);
    dbg_write(32'h08, 32'h3333_3333);
    dbg_write(32'h10, 32'h5555_5555);
    dbg_write(32'h14, 32'h6666_6666);
    dbg_write(32'h20, 32'h8888_8888);
    dbg_write(32'h30, 32'hCCCC_CCCC);
    dbg_write(32'h40, 32'h4444_4444);
    dbg_write(32'h1FC, 32'h7777_7777);  // aliases to word 63
    check("debug_pc_frozen", bus.o_pc, 32'h0);
    check("debug_instr_hold", bus.o_instruction, 32'h0);

    bus.i_debug_unit = 1'b0;
    bus.i_mem_wen    = 1'b0;
    bus.i_mem_ren    = 1'b1;
    tick();
    check("seq0_instr", bus.o_instruction, 32'h1111_1111);
    check("seq0_pc", bus.o_pc, 32'h4);
    tick();
    check("seq1_instr", bus.o_instruction, 32'h2222_2222);
    check("seq1_pc", bus.o_pc, 32'h8);

    // Jump taken at pc=8
    bus.i_jump_or_branch = 1'b1;
    bus.i_pc_src = 2'b10;
    bus.i_addr_jump = 32'h40;
    tick();
    check("jump_pc", bus.o_pc, 32'h40);
    check("jump_slot_instr", bus.o_instruction, NOP_ON ? 32'hF800_0000 : 32'h3333_3333);
    bus.i_jump_or_branch = 1'b0;
    tick();
    check("jump_dest_instr", bus.o_instruction, 32'h4444_4444);
    check("jump_dest_pc", bus.o_pc, 32'h44);

    // Target select
    bus.i_jump_or_branch = 1'b1;
    bus.i_addr_register = 32'h20;
    bus.i_addr_branch = 32'h30;
    bus.i_pc_src = 2'b00;
    tick();
    check("sel00_pc", bus.o_pc, 32'h20);
    bus.i_pc_src = 2'b01;
    tick();
    check("sel01_pc", bus.o_pc, 32'h30);
    check("sel01_instr", bus.o_instruction, NOP_ON ? 32'hF800_0000 : 32'h8888_8888);
    bus.i_pc_src = 2'b11;
    tick();
    check("sel11_pc", bus.o_pc, 32'h20);
    check("sel11_instr", bus.o_instruction, NOP_ON ? 32'hF800_0000 : 32'hCCCC_CCCC);

    // Stall at pc=0x10
    bus.i_pc_src = 2'b10;
    bus.i_addr_jump = 32'h10;
    tick();
    check("to10_pc", bus.o_pc, 32'h10);
    bus.i_jump_or_branch = 1'b0;
    held = bus.o_instruction;
    bus.i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", bus.o_pc, 32'h10);
      check("stall_instr", bus.o_instruction, held);
    end
    bus.i_stall = 1'b0;
    tick();
    check("unstall_pc", bus.o_pc, 32'h14);
    check("unstall_instr", bus.o_instruction, 32'h5555_5555);
    tick();
    check("unstall2_pc", bus.o_pc, 32'h18);
    check("unstall2_instr", bus.o_instruction, 32'h6666_6666);

    // PC wrap and aliased fetch
    bus.i_jump_or_branch = 1'b1;
    bus.i_pc_src = 2'b00;
    bus.i_addr_register = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc", bus.o_pc, 32'hFFFF_FFFC);
    check("wrap_next_pc", bus.o_next_pc, 32'h0);
    bus.i_jump_or_branch = 1'b0;
    tick();
    check("wrap_seq_pc", bus.o_pc, 32'h0);
    check("wrap_alias_instr", bus.o_instruction, 32'h7777_7777);
    tick();
    check("after_wrap_instr", bus.o_instruction, 32'h1111_1111);

    // Reset mid-run keeps memory
    rst = 1'b1;
    tick();
    check("midrst_pc", bus.o_pc, 32'h0);
    check("midrst_instr", bus.o_instruction, 32'h0);
    rst = 1'b0;
    tick();
    check("postrst_instr", bus.o_instruction, 32'h1111_1111);
    check("postrst_pc", bus.o_pc, 32'h4);

    // Read-before-write through the debug address
    bus.i_debug_unit = 1'b1;
    bus.i_mem_wen = 1'b1;
    bus.i_wr_addr = 32'h08;
    bus.i_mem_data = 32'hABCD_ABCD;
    tick();
    check("rbw_old_word", bus.o_instruction, 32'h3333_3333);
    check("rbw_pc_frozen", bus.o_pc, 32'h4);
    bus.i_mem_wen = 1'b0;
    tick();
    check("rbw_new_word", bus.o_instruction, 32'hABCD_ABCD);

    // Read disabled holds the instruction while the PC advances
    bus.i_debug_unit = 1'b0;
    bus.i_mem_ren = 1'b0;
    tick();
    check("ren_off_pc", bus.o_pc, 32'h8);
    check("ren_off_instr", bus.o_instruction, 32'hABCD_ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS pipeline: the program counter register, the PC+4 incrementer and a word-wide instruction memory in one block. It selects the next PC from sequential, register, branch or jump targets and presents the fetched instruction, current PC and PC+4 to the IF/ID register. A debug port lets the debug unit load program words into instruction memory before execution.

## Interface
- NB_INST, 32: instruction width in bits.
- NB_DATA, 32: address / PC width in bits.
- MEM_SIZEB, 256: instruction memory size in bytes; must be a multiple of 4 and a power of two; depth = MEM_SIZEB/4 words.
- i_clk  in  1  single clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_stall  in  1  high freezes the PC and the instruction output register.
- i_debug_unit  in  1  high routes i_wr_addr to the memory and freezes the PC.
- i_mem_wen  in  1  memory write enable (honoured only while i_debug_unit=1).
- i_mem_ren  in  1  memory read enable.
- i_mem_data  in  NB_INST  word to write.
- i_wr_addr  in  NB_DATA  debug byte address for write/read.
- i_pc_src  in  2  target select: 00 register, 01 branch, 10 jump, 11 register.
- i_addr_register  in  NB_DATA  jump-register target.
- i_addr_branch  in  NB_DATA  branch target.
- i_addr_jump  in  NB_DATA  jump target.
- i_jump_or_branch  in  1  high: load selected target instead of PC+4.
- o_instruction  out  NB_INST  registered fetched instruction.
- o_pc  out  NB_DATA  current PC.
- o_next_pc  out  NB_DATA  current PC + 4 (combinational).

## Operation
- Memory: array of MEM_SIZEB/4 words of NB_INST bits; word index = address[log2(MEM_SIZEB)-1:2]; bits [1:0] and bits above the index ignored (aliasing).
- Memory address = i_wr_addr when i_debug_unit=1, else o_pc.
- Write: i_debug_unit=1 and i_mem_wen=1 at clock edge stores i_mem_data at that word; independent of i_stall; not blocked by reset.
- Read: when i_stall=0 and i_mem_ren=1, o_instruction loads mem[addr] at the clock edge; otherwise it holds. Simultaneous write and read to same word returns the old word (read-before-write).
- o_next_pc = o_pc + 4, modulo 2^NB_DATA (wraps 0xFFFFFFFC -> 0x00000000).
- Next PC = target chosen by i_pc_src if i_jump_or_branch=1, else o_next_pc. Targets loaded unmodified (no alignment forcing).
- PC updates when i_stall=0 and i_debug_unit=0; otherwise holds.
- Reset: o_pc=0, o_instruction=0; memory contents preserved. Reset has priority over stall and PC update.

## Timing
- PC register: new value visible one cycle after the edge where update is enabled.
- Instruction read latency: 1 cycle; o_instruction after edge N holds mem[o_pc value before edge N].
- Taken jump/branch asserted in cycle N: o_pc = target after edge N; instruction at the old PC still emitted (delay slot), unless the macro below is enabled.
- Stall deasserted after k cycles: PC and o_instruction resume exactly where frozen, no skipped or repeated fetch.
- Reset mid-run: next edge forces o_pc=0, o_instruction=0; first real instruction (mem[0]) appears one cycle after reset release.

## Configuration
- FETCH_BRANCH_NOP_EN: when defined, on an edge where i_jump_or_branch=1 and the read is enabled, o_instruction loads NOP 32'hF8000000 instead of the memory word (squashes the delay slot). When undefined, the memory word is always loaded (delayed-branch semantics).

## Test plan
- Reset: assert i_reset one cycle -> o_pc=0, o_instruction=0, o_next_pc=4.
- Debug load: i_debug_unit=1, write 0x11111111/0x22222222/0x33333333 to addresses 0,4,8, release, run -> o_instruction sequence 0x11111111, 0x22222222, 0x33333333 with o_pc 0,4,8.
- Jump: at o_pc=8 assert i_jump_or_branch, i_pc_src=10, i_addr_jump=0x40 -> next o_pc=0x40; o_instruction = word at 8 (macro off) or 0xF8000000 (macro on).
- Target select: i_pc_src=00/01/11 with register=0x20, branch=0x30 -> o_pc 0x20, 0x30, 0x20.
- Stall: hold i_stall=1 for 3 cycles at o_pc=0x10 -> o_pc and o_instruction unchanged; release -> o_pc=0x14 next edge.
- Wrap: load i_addr_register=0xFFFFFFFC -> o_next_pc=0; next sequential o_pc=0, instruction fetched from word index 63 (aliased).
